// File: rtl/ae350_reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : ae350_reset_sequencer
//  Purpose  : AE350 bring-up sequencer. It filters PLL lock, supervises DDR3
//             calibration with bounded retries and staggers domain releases.
//  Revision : 1.0  initial release
// ============================================================================
module ae350_reset_sequencer #(
    parameter int N_DOMAINS    = 4,
    parameter int LOCK_FILT    = 16,
    parameter int STAGE_DLY    = 8,
    parameter int INIT_TIMEOUT = 65536,
    parameter int MAX_RETRY    = 3,
    parameter int DEB_CYCLES   = 1000
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic                           PLL_LOCK,
    input  logic                           DDR3_INIT,
    input  logic                           RST_KEY_N,
    output logic                           DDR3_RSTN,
    output logic [N_DOMAINS-1:0]           DOMAIN_RSTN,
    output logic [2:0]                     STATE,
    output logic                           FAIL,
    output logic [$clog2(MAX_RETRY+1)-1:0] RETRY_CNT
);

    localparam int c_RETRY_W = $clog2(MAX_RETRY + 1);
    localparam int c_CNT_MAX = (INIT_TIMEOUT > LOCK_FILT)
                             ? ((INIT_TIMEOUT > STAGE_DLY) ? INIT_TIMEOUT : STAGE_DLY)
                             : ((LOCK_FILT > STAGE_DLY) ? LOCK_FILT : STAGE_DLY);
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    localparam int c_DEB_W   = $clog2(DEB_CYCLES + 1);

    localparam logic [c_CNT_W-1:0]   c_LOCK_DONE  = c_CNT_W'(LOCK_FILT);
    localparam logic [c_CNT_W-1:0]   c_INIT_LAST  = c_CNT_W'(INIT_TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0]   c_STAGE_LAST = c_CNT_W'(STAGE_DLY - 1);
    localparam logic [c_CNT_W-1:0]   c_CNT_ONE    = c_CNT_W'(1);
    localparam logic [c_DEB_W-1:0]   c_DEB_DONE   = c_DEB_W'(DEB_CYCLES);
    localparam logic [c_DEB_W-1:0]   c_DEB_ONE    = c_DEB_W'(1);
    localparam logic [c_RETRY_W-1:0] c_RETRY_MAX  = c_RETRY_W'(MAX_RETRY);
    localparam logic [c_RETRY_W-1:0] c_RETRY_ONE  = c_RETRY_W'(1);

    localparam logic [2:0] c_ST_RESET     = 3'd0;
    localparam logic [2:0] c_ST_WAIT_LOCK = 3'd1;
    localparam logic [2:0] c_ST_DDR_INIT  = 3'd2;
    localparam logic [2:0] c_ST_RELEASE   = 3'd3;
    localparam logic [2:0] c_ST_RUN       = 3'd4;
    localparam logic [2:0] c_ST_FAIL      = 3'd5;

    logic                 r_lock_meta, r_lock_s;
    logic                 r_init_meta, r_init_s;
    logic                 r_key_meta, r_key_s, r_key_db, r_key_press;
    logic [c_DEB_W-1:0]   r_deb_cnt;
    logic                 r_abort_req;
    logic [2:0]           r_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_ddr3_rstn;
    logic [N_DOMAINS-1:0] r_domain_rstn;
    logic                 r_fail;
    logic [c_RETRY_W-1:0] r_retry_cnt;

    logic                 w_active;
    logic                 w_abort_cond;
    logic [N_DOMAINS-1:0] w_rel_next;

    assign w_active = (r_state == c_ST_DDR_INIT) || (r_state == c_ST_RELEASE) ||
                      (r_state == c_ST_RUN);
    // The abort request is registered, adding one cycle behind the synchronisers.
    assign w_abort_cond = w_active &&
                          (!r_lock_s || (!r_init_s && (r_state != c_ST_DDR_INIT)));

    always_comb begin
        w_rel_next[0] = 1'b1;
        for (int i = 1; i < N_DOMAINS; i++) begin
            w_rel_next[i] = r_domain_rstn[i-1];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_lock_meta   <= 1'b0;
            r_lock_s      <= 1'b0;
            r_init_meta   <= 1'b0;
            r_init_s      <= 1'b0;
            r_key_meta    <= 1'b1;
            r_key_s       <= 1'b1;
            r_key_db      <= 1'b1;
            r_key_press   <= 1'b0;
            r_deb_cnt     <= '0;
            r_abort_req   <= 1'b0;
            r_state       <= c_ST_RESET;
            r_cnt         <= '0;
            r_ddr3_rstn   <= 1'b0;
            r_domain_rstn <= '0;
            r_fail        <= 1'b0;
            r_retry_cnt   <= '0;
        end else begin
            r_lock_meta <= PLL_LOCK;
            r_lock_s    <= r_lock_meta;
            r_init_meta <= DDR3_INIT;
            r_init_s    <= r_init_meta;
            r_key_meta  <= RST_KEY_N;
            r_key_s     <= r_key_meta;

            r_key_press <= 1'b0;
            if (r_key_s != r_key_db) begin
                if (r_deb_cnt == c_DEB_DONE) begin
                    r_key_db    <= r_key_s;
                    r_deb_cnt   <= '0;
                    r_key_press <= ~r_key_s;
                end else begin
                    r_deb_cnt <= r_deb_cnt + c_DEB_ONE;
                end
            end else begin
                r_deb_cnt <= '0;
            end

            r_abort_req <= w_abort_cond;

            if (r_key_press && (r_state != c_ST_RESET)) begin
                r_state       <= c_ST_WAIT_LOCK;
                r_cnt         <= '0;
                r_ddr3_rstn   <= 1'b0;
                r_domain_rstn <= '0;
                r_abort_req   <= 1'b0;
                r_fail        <= 1'b0;
                r_retry_cnt   <= '0;
            end else if (r_abort_req && w_active) begin
                r_state       <= c_ST_WAIT_LOCK;
                r_cnt         <= '0;
                r_ddr3_rstn   <= 1'b0;
                r_domain_rstn <= '0;
                r_abort_req   <= 1'b0;
            end else begin
                case (r_state)
                    c_ST_RESET: begin
                        r_state <= c_ST_WAIT_LOCK;
                        r_cnt   <= '0;
                    end
                    c_ST_WAIT_LOCK: begin
                        if (!r_lock_s) begin
                            r_cnt <= '0;
                        end else if (r_cnt == c_LOCK_DONE) begin
                            r_state     <= c_ST_DDR_INIT;
                            r_ddr3_rstn <= 1'b1;
                            r_cnt       <= '0;
                        end else begin
                            r_cnt <= r_cnt + c_CNT_ONE;
                        end
                    end
                    c_ST_DDR_INIT: begin
                        // Timeout outranks a calibration-done seen on the same cycle.
                        if (r_cnt == c_INIT_LAST) begin
                            r_ddr3_rstn <= 1'b0;
                            r_cnt       <= '0;
                            if (r_retry_cnt < c_RETRY_MAX) begin
                                r_retry_cnt <= r_retry_cnt + c_RETRY_ONE;
                                r_state     <= c_ST_WAIT_LOCK;
                            end else begin
                                r_state <= c_ST_FAIL;
                                r_fail  <= 1'b1;
                            end
                        end else if (r_init_s) begin
                            r_state <= c_ST_RELEASE;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + c_CNT_ONE;
                        end
                    end
                    c_ST_RELEASE: begin
                        if (r_cnt == c_STAGE_LAST) begin
                            r_domain_rstn <= w_rel_next;
                            r_cnt         <= '0;
                            if (&w_rel_next) begin
                                r_state <= c_ST_RUN;
                            end
                        end else begin
                            r_cnt <= r_cnt + c_CNT_ONE;
                        end
                    end
                    c_ST_RUN: begin
                        r_ddr3_rstn   <= 1'b1;
                        r_domain_rstn <= '1;
                    end
                    c_ST_FAIL: begin
                        r_ddr3_rstn   <= 1'b0;
                        r_domain_rstn <= '0;
                        r_fail        <= 1'b1;
                    end
                    default: begin
                        r_state       <= c_ST_WAIT_LOCK;
                        r_cnt         <= '0;
                        r_ddr3_rstn   <= 1'b0;
                        r_domain_rstn <= '0;
                    end
                endcase
            end
        end
    end

    assign DDR3_RSTN   = r_ddr3_rstn;
    assign DOMAIN_RSTN = r_domain_rstn;
    assign STATE       = r_state;
    assign FAIL        = r_fail;
    assign RETRY_CNT   = r_retry_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ae350_reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ae350_reset_sequencer
//  Purpose  : Directed bench for ae350_reset_sequencer with an edge-stamped
//             expectation queue.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ae350_reset_sequencer;

    logic       CLK = 1'b0;
    logic       RST;
    logic       PLL_LOCK;
    logic       DDR3_INIT;
    logic       RST_KEY_N;
    logic       DDR3_RSTN;
    logic [3:0] DOMAIN_RSTN;
    logic [2:0] STATE;
    logic       FAIL;
    logic [1:0] RETRY_CNT;

    int checks   = 0;
    int failures = 0;
    int edge_cnt = 0;

    int          q_edge[$];
    string       q_tag[$];
    logic [10:0] q_val[$];

    int          e_no;
    string       e_tag;
    logic [10:0] e_val;
    logic [10:0] w_obs;

    ae350_reset_sequencer #(
        .N_DOMAINS   (4),
        .LOCK_FILT   (4),
        .STAGE_DLY   (3),
        .INIT_TIMEOUT(20),
        .MAX_RETRY   (2),
        .DEB_CYCLES  (5)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .PLL_LOCK   (PLL_LOCK),
        .DDR3_INIT  (DDR3_INIT),
        .RST_KEY_N  (RST_KEY_N),
        .DDR3_RSTN  (DDR3_RSTN),
        .DOMAIN_RSTN(DOMAIN_RSTN),
        .STATE      (STATE),
        .FAIL       (FAIL),
        .RETRY_CNT  (RETRY_CNT)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) edge_cnt <= edge_cnt + 1;

    assign w_obs = {DDR3_RSTN, DOMAIN_RSTN, STATE, FAIL, RETRY_CNT};

    // Expectation fields: ddr3_rstn, domain_rstn, state, fail, retry_cnt.
    task automatic expect_at(input int e, input string tag, input logic ddr,
                             input logic [3:0] dom, input logic [2:0] st,
                             input logic f, input logic [1:0] rc);
        q_edge.push_back(e);
        q_tag.push_back(tag);
        q_val.push_back({ddr, dom, st, f, rc});
    endtask

    task automatic wait_edge(input int e);
        while (edge_cnt < e) @(negedge CLK);
    endtask

    always @(negedge CLK) begin
        while (q_edge.size() > 0 && q_edge[0] <= edge_cnt) begin
            e_no  = q_edge.pop_front();
            e_tag = q_tag.pop_front();
            e_val = q_val.pop_front();
            checks++;
            assert (e_no == edge_cnt && w_obs === e_val) else begin
                failures++;
                $error("FAIL %s edge=%0d {rstn,dom,state,fail,retry} observed=%b expected=%b",
                       e_tag, e_no, w_obs, e_val);
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        RST       = 1'b1;
        PLL_LOCK  = 1'b0;
        DDR3_INIT = 1'b0;
        RST_KEY_N = 1'b1;

        expect_at(2, "reset_values", 1'b0, 4'b0000, 3'd0, 1'b0, 2'd0);
        expect_at(4, "leave_reset",  1'b0, 4'b0000, 3'd1, 1'b0, 2'd0);
        wait_edge(3);
        RST = 1'b0;

        // Clean bring-up: lock sampled at edge 10, init at edge 24.
        expect_at(15, "lock_filter_hold", 1'b0, 4'b0000, 3'd1, 1'b0, 2'd0);
        expect_at(16, "ddr3_release",     1'b1, 4'b0000, 3'd2, 1'b0, 2'd0);
        expect_at(25, "ddr_init_wait",    1'b1, 4'b0000, 3'd2, 1'b0, 2'd0);
        expect_at(26, "enter_release",    1'b1, 4'b0000, 3'd3, 1'b0, 2'd0);
        expect_at(29, "dom0_release",     1'b1, 4'b0001, 3'd3, 1'b0, 2'd0);
        expect_at(32, "dom1_release",     1'b1, 4'b0011, 3'd3, 1'b0, 2'd0);
        expect_at(35, "dom2_release",     1'b1, 4'b0111, 3'd3, 1'b0, 2'd0);
        expect_at(37, "dom3_pending",     1'b1, 4'b0111, 3'd3, 1'b0, 2'd0);
        expect_at(38, "dom3_run",         1'b1, 4'b1111, 3'd4, 1'b0, 2'd0);
        wait_edge(9);
        PLL_LOCK = 1'b1;
        wait_edge(23);
        DDR3_INIT = 1'b1;

        // Lock loss in RUN, sampled at edge 50.
        expect_at(52, "lockloss_hold",  1'b1, 4'b1111, 3'd4, 1'b0, 2'd0);
        expect_at(53, "lockloss_abort", 1'b0, 4'b0000, 3'd1, 1'b0, 2'd0);
        wait_edge(49);
        PLL_LOCK  = 1'b0;
        DDR3_INIT = 1'b0;

        // Three-cycle lock glitch, then stable lock from edge 80.
        expect_at(66, "glitch_reject",   1'b0, 4'b0000, 3'd1, 1'b0, 2'd0);
        expect_at(79, "glitch_idle",     1'b0, 4'b0000, 3'd1, 1'b0, 2'd0);
        expect_at(85, "relock_hold",     1'b0, 4'b0000, 3'd1, 1'b0, 2'd0);
        expect_at(86, "relock_release",  1'b1, 4'b0000, 3'd2, 1'b0, 2'd0);
        // Calibration never completes: two retries, then FAIL.
        expect_at(105, "timeout1_before", 1'b1, 4'b0000, 3'd2, 1'b0, 2'd0);
        expect_at(106, "timeout1",        1'b0, 4'b0000, 3'd1, 1'b0, 2'd1);
        expect_at(111, "retry1_release",  1'b1, 4'b0000, 3'd2, 1'b0, 2'd1);
        expect_at(131, "timeout2",        1'b0, 4'b0000, 3'd1, 1'b0, 2'd2);
        expect_at(136, "retry2_release",  1'b1, 4'b0000, 3'd2, 1'b0, 2'd2);
        expect_at(155, "timeout3_before", 1'b1, 4'b0000, 3'd2, 1'b0, 2'd2);
        expect_at(156, "enter_fail",      1'b0, 4'b0000, 3'd5, 1'b1, 2'd2);
        expect_at(170, "fail_sticky",     1'b0, 4'b0000, 3'd5, 1'b1, 2'd2);
        wait_edge(59);
        PLL_LOCK = 1'b1;
        wait_edge(62);
        PLL_LOCK = 1'b0;
        wait_edge(79);
        PLL_LOCK = 1'b1;

        // Key held low for 7 samples from edge 180 recovers from FAIL.
        expect_at(187, "key_pending",     1'b0, 4'b0000, 3'd5, 1'b1, 2'd2);
        expect_at(188, "key_recover",     1'b0, 4'b0000, 3'd1, 1'b0, 2'd0);
        expect_at(193, "post_key_ddr",    1'b1, 4'b0000, 3'd2, 1'b0, 2'd0);
        expect_at(213, "retry_timeout",   1'b0, 4'b0000, 3'd1, 1'b0, 2'd1);
        expect_at(218, "retry_ddr",       1'b1, 4'b0000, 3'd2, 1'b0, 2'd1);
        expect_at(224, "retry_release",   1'b1, 4'b0000, 3'd3, 1'b0, 2'd1);
        expect_at(227, "retry_dom0",      1'b1, 4'b0001, 3'd3, 1'b0, 2'd1);
        expect_at(236, "retry_run",       1'b1, 4'b1111, 3'd4, 1'b0, 2'd1);
        wait_edge(179);
        RST_KEY_N = 1'b0;
        wait_edge(186);
        RST_KEY_N = 1'b1;
        wait_edge(221);
        DDR3_INIT = 1'b1;

        // Lock loss with a nonzero retry count keeps the count.
        expect_at(252, "lockloss2_hold",  1'b1, 4'b1111, 3'd4, 1'b0, 2'd1);
        expect_at(253, "lockloss2_abort", 1'b0, 4'b0000, 3'd1, 1'b0, 2'd1);
        expect_at(266, "relock2_ddr",     1'b1, 4'b0000, 3'd2, 1'b0, 2'd1);
        expect_at(267, "relock2_release", 1'b1, 4'b0000, 3'd3, 1'b0, 2'd1);
        expect_at(279, "relock2_run",     1'b1, 4'b1111, 3'd4, 1'b0, 2'd1);
        wait_edge(249);
        PLL_LOCK = 1'b0;
        wait_edge(259);
        PLL_LOCK = 1'b1;

        // Key bouncing every 2 cycles must be ignored.
        expect_at(310, "bounce_mid", 1'b1, 4'b1111, 3'd4, 1'b0, 2'd1);
        expect_at(340, "bounce_end", 1'b1, 4'b1111, 3'd4, 1'b0, 2'd1);
        for (int i = 0; i < 40; i++) begin
            wait_edge(289 + i);
            RST_KEY_N = ((i / 2) % 2) == 1;
        end
        RST_KEY_N = 1'b1;

        // Calibration loss in RUN, sampled at edge 350.
        expect_at(352, "initloss_hold",  1'b1, 4'b1111, 3'd4, 1'b0, 2'd1);
        expect_at(353, "initloss_abort", 1'b0, 4'b0000, 3'd1, 1'b0, 2'd1);
        expect_at(358, "pre_rst_ddr",    1'b1, 4'b0000, 3'd2, 1'b0, 2'd1);
        expect_at(361, "pre_rst_hold",   1'b1, 4'b0000, 3'd2, 1'b0, 2'd1);
        expect_at(362, "mid_rst",        1'b0, 4'b0000, 3'd0, 1'b0, 2'd0);
        expect_at(363, "mid_rst_held",   1'b0, 4'b0000, 3'd0, 1'b0, 2'd0);
        expect_at(364, "post_rst",       1'b0, 4'b0000, 3'd1, 1'b0, 2'd0);
        wait_edge(349);
        DDR3_INIT = 1'b0;
        wait_edge(361);
        RST = 1'b1;
        wait_edge(363);
        RST = 1'b0;

        wait_edge(370);
        checks++;
        assert (q_edge.size() == 0) else begin
            failures++;
            $error("FAIL scoreboard_drain pending=%0d required=0", q_edge.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
